// File: rtl/jk_drive_seq_pkg.sv
// Shared state encoding, policy constants and the JK excitation rule
// used by the jk_drive_seq drive side.
package jk_drive_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    localparam int POLICY_SET_RESET = 0;
    localparam int POLICY_TOGGLE    = 1;

    typedef struct packed {
        logic j;
        logic k;
    } jk_cmd_t;

    // J/K needed to move a JK flip-flop from q_cur to target on the next edge.
    function automatic jk_cmd_t excite(input logic q_cur, input logic target, input int policy);
        jk_cmd_t cmd;
        cmd = '{j: 1'b0, k: 1'b0};
        if (target != q_cur) begin
            if (policy == POLICY_TOGGLE) begin
                cmd = '{j: 1'b1, k: 1'b1};
            end else begin
                cmd = '{j: target, k: ~target};
            end
        end
        return cmd;
    endfunction

endpackage

// File: rtl/jk_drive_seq_bit_fifo.sv
// 1-bit synchronous FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module jk_drive_seq_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_bit,
    input  logic pop,
    output logic pop_bit,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_bit = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_bit;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jk_drive_seq.sv
// Drive side of a JK flip-flop link: turns queued target bits into registered
// J/K commands and checks the returned Q two edges after each command.
module jk_drive_seq
    import jk_drive_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int POLICY = 0,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic             IN_BIT,
    output logic             IN_READY,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    input  logic             CLR_ERR,
    output logic             ACTIVE,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic fifo_push, fifo_pop, fifo_bit, fifo_full, fifo_empty;

    state_e           state_q, state_d;
    jk_cmd_t          jk_q, jk_d;
    logic             q_model_q, q_model_d;
    logic             exp_v_q, exp_v_d;
    logic             chk_v_q, chk_v_d;
    logic             chk_exp_q, chk_exp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign IN_READY  = !fifo_full;
    assign fifo_push = IN_VALID && IN_READY;

    jk_drive_seq_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (fifo_push),
        .push_bit (IN_BIT),
        .pop      (fifo_pop),
        .pop_bit  (fifo_bit),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        jk_d      = '{j: 1'b0, k: 1'b0};
        q_model_d = q_model_q;
        exp_v_d   = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_INIT: begin
                jk_d    = '{j: 1'b0, k: 1'b1};
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    jk_d      = excite(q_model_q, fifo_bit, POLICY);
                    q_model_d = fifo_bit;
                    exp_v_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Clear is applied before the mismatch so a coincident error still counts as one.
    always_comb begin
        chk_v_d   = exp_v_q;
        chk_exp_d = q_model_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (CLR_ERR) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
        if (chk_v_q && (Q_FB != chk_exp_q)) begin
            err_d = 1'b1;
            if (err_cnt_d != CNT_MAX) begin
                err_cnt_d = err_cnt_d + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments here so every flop samples its _d value from the same instant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_INIT;
            jk_q      <= '{j: 1'b0, k: 1'b0};
            q_model_q <= 1'b0;
            exp_v_q   <= 1'b0;
            chk_v_q   <= 1'b0;
            chk_exp_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            jk_q      <= jk_d;
            q_model_q <= q_model_d;
            exp_v_q   <= exp_v_d;
            chk_v_q   <= chk_v_d;
            chk_exp_q <= chk_exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign J       = jk_q.j;
    assign K       = jk_q.k;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
    assign ACTIVE  = !fifo_empty || exp_v_q || chk_v_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq: three instances (set/reset, toggle, 2-bit counter)
// each closing the loop through a behavioural JK flip-flop.
module tb_jk_drive_seq;

    localparam int DEPTH = 4;
    localparam int NI    = 3;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit   = 1'b0;
    logic clr_err  = 1'b0;
    logic force_en = 1'b0;

    logic       j_o [NI];
    logic       k_o [NI];
    logic       rdy_o [NI];
    logic       act_o [NI];
    logic       err_o [NI];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    logic [NI-1:0] ff_q = '1;
    logic [NI-1:0] q_fb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign q_fb = force_en ? '0 : ff_q;

    jk_drive_seq #(.DEPTH(DEPTH), .POLICY(0), .CNT_W(8)) dut0 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_BIT(in_bit), .IN_READY(rdy_o[0]),
        .J(j_o[0]), .K(k_o[0]), .Q_FB(q_fb[0]), .CLR_ERR(clr_err),
        .ACTIVE(act_o[0]), .ERR(err_o[0]), .ERR_CNT(cnt0));

    jk_drive_seq #(.DEPTH(DEPTH), .POLICY(1), .CNT_W(8)) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_BIT(in_bit), .IN_READY(rdy_o[1]),
        .J(j_o[1]), .K(k_o[1]), .Q_FB(q_fb[1]), .CLR_ERR(clr_err),
        .ACTIVE(act_o[1]), .ERR(err_o[1]), .ERR_CNT(cnt1));

    jk_drive_seq #(.DEPTH(DEPTH), .POLICY(0), .CNT_W(2)) dut2 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_BIT(in_bit), .IN_READY(rdy_o[2]),
        .J(j_o[2]), .K(k_o[2]), .Q_FB(q_fb[2]), .CLR_ERR(clr_err),
        .ACTIVE(act_o[2]), .ERR(err_o[2]), .ERR_CNT(cnt2));

    // External JK flip-flops (not reset: INIT must force them to 0).
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            case ({j_o[i], k_o[i]})
                2'b01:   ff_q[i] <= 1'b0;
                2'b10:   ff_q[i] <= 1'b1;
                2'b11:   ff_q[i] <= ~ff_q[i];
                default: ff_q[i] <= ff_q[i];
            endcase
        end
    end

    // ---------------- reference model ----------------
    int          pol     [NI] = '{0, 1, 0};
    int          cnt_max [NI] = '{255, 255, 3};
    bit          fq[$];
    int unsigned since_rst;
    int          m_pre;
    logic        m_q, m_tgt;
    logic [1:0]  m_jk [NI];
    bit          h1_v, h2_v;
    logic        h1_t, h2_t;
    logic        m_err [NI];
    int          m_cnt [NI];
    logic [38:0] exp_w, obs_w;

    function automatic logic [1:0] jk_for(input logic cur, input logic tgt, input int p);
        if (cur == tgt) return 2'b00;
        if (p == 1) return 2'b11;
        return {tgt, ~tgt};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            since_rst = 0;
            m_q  = 1'b0;
            h1_v = 1'b0; h2_v = 1'b0; h1_t = 1'b0; h2_t = 1'b0;
            for (int i = 0; i < NI; i++) begin
                m_jk[i] = 2'b00; m_err[i] = 1'b0; m_cnt[i] = 0;
            end
        end else begin
            m_pre = fq.size();
            for (int i = 0; i < NI; i++) begin
                if (clr_err) begin
                    m_err[i] = 1'b0; m_cnt[i] = 0;
                end
                if (h2_v && (q_fb[i] !== h2_t)) begin
                    m_err[i] = 1'b1;
                    if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                end
            end
            h2_v = h1_v; h2_t = h1_t; h1_v = 1'b0;
            if (since_rst == 0) begin
                for (int i = 0; i < NI; i++) m_jk[i] = 2'b01;
            end else if (since_rst == 1 || m_pre == 0) begin
                for (int i = 0; i < NI; i++) m_jk[i] = 2'b00;
            end else begin
                m_tgt = fq.pop_front();
                for (int i = 0; i < NI; i++) m_jk[i] = jk_for(m_q, m_tgt, pol[i]);
                m_q  = m_tgt;
                h1_v = 1'b1; h1_t = m_tgt;
            end
            if (in_valid && m_pre < DEPTH) fq.push_back(in_bit);
            if (since_rst < 2) since_rst++;
        end
        for (int i = 0; i < NI; i++) begin
            exp_w[i*13 +: 13] = {m_jk[i], fq.size() < DEPTH, (fq.size() != 0) || h1_v || h2_v,
                                 m_err[i], 8'(m_cnt[i])};
        end
    end

    always_comb begin
        obs_w[12:0]  = {j_o[0], k_o[0], rdy_o[0], act_o[0], err_o[0], cnt0};
        obs_w[25:13] = {j_o[1], k_o[1], rdy_o[1], act_o[1], err_o[1], cnt1};
        obs_w[38:26] = {j_o[2], k_o[2], rdy_o[2], act_o[2], err_o[2], 6'b0, cnt2};
    end

    logic [1:0] jk_p0 [5] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [1:0] jk_p1 [5] = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    logic       bits  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0; clr_err = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({j_o[i], k_o[i], rdy_o[i], act_o[i], err_o[i]} !== 5'b00100) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%b want=00100", i,
                         {j_o[i], k_o[i], rdy_o[i], act_o[i], err_o[i]});
            end
        end
        checks++;
        if ({cnt0, cnt1, cnt2} !== 18'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h want=0", {cnt0, cnt1, cnt2});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({j_o[i], k_o[i]} !== ((c == 0) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL init_jk inst=%0d cyc=%0d got=%b", i, c, {j_o[i], k_o[i]});
                end
            end
        end
        checks++;
        if (ff_q !== 3'b000 || rdy_o[0] !== 1'b1 || err_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL init_forced q=%b rdy=%b err=%b want q=000 rdy=1 err=0",
                     ff_q, rdy_o[0], err_o[0]);
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL stream_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({j_o[0], k_o[0]} !== jk_p0[c-2] || {j_o[1], k_o[1]} !== jk_p1[c-2]) begin
                    failures++;
                    $display("FAIL stream_jk cyc=%0d got p0=%b p1=%b want p0=%b p1=%b", c,
                             {j_o[0], k_o[0]}, {j_o[1], k_o[1]}, jk_p0[c-2], jk_p1[c-2]);
                end
            end
            if (c >= 3 && c <= 7) begin
                checks++;
                if (ff_q[0] !== bits[c-3] || ff_q[1] !== bits[c-3]) begin
                    failures++;
                    $display("FAIL stream_q cyc=%0d got=%b%b want=%b", c, ff_q[0], ff_q[1], bits[c-3]);
                end
            end
            in_valid = (c < 5);
            in_bit   = (c < 5) ? bits[c] : 1'b0;
        end
        checks++;
        if (err_o[0] !== 1'b0 || err_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL stream_err got=%b%b want=00", err_o[0], err_o[1]);
        end
    endtask

    task automatic test_fill();
        logic last_bit;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; last_bit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL fill_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            in_valid = (c < 30);
            if (c < 30) begin
                in_bit   = 1'($urandom_range(0, 1));
                last_bit = in_bit;
            end
        end
        checks++;
        if (ff_q[0] !== last_bit || ff_q[1] !== last_bit) begin
            failures++;
            $display("FAIL fill_last_q got=%b%b want=%b", ff_q[0], ff_q[1], last_bit);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            clr_err  = ($urandom_range(0, 7) == 0);
        end
        in_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_mismatch();
        apply_reset();
        force_en = 1'b1;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL mism_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (c == 8) begin
                checks++;
                if (err_o[0] !== 1'b1 || cnt0 !== 8'd3 || cnt2 !== 2'd3) begin
                    failures++;
                    $display("FAIL mism_three err=%b cnt0=%0d cnt2=%0d want 1/3/3", err_o[0], cnt0, cnt2);
                end
            end
            if (c == 15) begin
                checks++;
                if (err_o[0] !== 1'b1 || cnt0 !== 8'd1 || cnt2 !== 2'd1) begin
                    failures++;
                    $display("FAIL mism_clr_same err=%b cnt0=%0d cnt2=%0d want 1/1/1", err_o[0], cnt0, cnt2);
                end
            end
            if (c == 30) begin
                checks++;
                if (err_o[2] !== 1'b1 || cnt0 !== 8'd5 || cnt1 !== 8'd5 || cnt2 !== 2'd3) begin
                    failures++;
                    $display("FAIL mism_saturate err2=%b cnt0=%0d cnt1=%0d cnt2=%0d want 1/5/5/3",
                             err_o[2], cnt0, cnt1, cnt2);
                end
            end
            in_valid = (c < 3) || (c == 8) || (c >= 19 && c < 24);
            in_bit   = 1'b1;
            clr_err  = (c == 11) || (c == 15);
        end
        in_valid = 1'b0; clr_err = 1'b0; force_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL midrst_pre cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({j_o[i], k_o[i], rdy_o[i], act_o[i]} !== 4'b0010) begin
                failures++;
                $display("FAIL midrst_async inst=%0d got=%b want=0010", i,
                         {j_o[i], k_o[i], rdy_o[i], act_o[i]});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL midrst_model cyc=%0d got=%h want=%h", c, obs_w, exp_w);
            end
            checks++;
            if ({j_o[0], k_o[0]} !== ((c == 0) ? 2'b01 : 2'b00) || act_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL midrst_replay cyc=%0d got jk=%b act=%b", c, {j_o[0], k_o[0]}, act_o[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_random();
        test_mismatch();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
